// File: rtl/interrupt_controller_if.sv
// Signal bundle between the CPU-side decoder/peripherals and the interrupt controller.
// The controller is the slave; the master drives request lines, enables and the acknowledge.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
);
  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_en;
  logic               IntReset;
  logic               Interrupt;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq_in,
    output irq_en,
    output IntReset,
    input  Interrupt,
    input  irq_id,
    input  pending
  );

  modport slave (
    input  irq_in,
    input  irq_en,
    input  IntReset,
    output Interrupt,
    output irq_id,
    output pending
  );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: synchronises asynchronous request lines, latches
// rising edges as pending flags and presents one request at a time to the CPU with a level ack.
module interrupt_controller #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  interrupt_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACKD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [NUM_IRQ-1:0] sync3_q, sync3_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               interrupt_q, interrupt_d;

  logic [NUM_IRQ-1:0] irq_event;
  logic [NUM_IRQ-1:0] candidates;
  logic               any_candidate;
  logic [ID_W-1:0]    lowest_id;

  // Third stage only delays the synchronised level so a rise shows up for exactly one cycle.
  assign irq_event     = sync2_q & ~sync3_q;
  assign candidates    = pending_q & bus.irq_en;
  assign any_candidate = |candidates;

  // Scanning from the top down leaves the lowest set index as the final winner.
  always_comb begin
    lowest_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (candidates[i]) lowest_id = ID_W'(i);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sync1_d   = bus.irq_in;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    pending_d = pending_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_candidate) begin
          irq_id_d = lowest_id;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.IntReset) begin
          pending_d[irq_id_q] = 1'b0;
          state_d             = S_ACKD;
        end
      end
      S_ACKD: begin
        // Wait for the ack level to drop so a long ack is consumed once.
        if (!bus.IntReset) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Applied after the clear so a new edge on the serviced line survives the ack.
    pending_d   = pending_d | (irq_event & bus.irq_en);
    interrupt_d = (state_d == S_REQ);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      pending_q   <= '0;
      irq_id_q    <= '0;
      interrupt_q <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      pending_q   <= pending_d;
      irq_id_q    <= irq_id_d;
      interrupt_q <= interrupt_d;
      state_q     <= state_d;
    end
  end

  assign bus.Interrupt = interrupt_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.pending   = pending_q;

endmodule
